// File: rtl/pong_pkg.sv
// Shared definitions for the Pong push-button conditioner.
// Holds the per-button FSM encoding, button bit positions, default timing
// and the helper used to size the shared cycle counters.
package pong_pkg;

    // Per-button debounce FSM states
    typedef enum logic [1:0] {
        S_RELEASED    = 2'd0,
        S_PRESS_CHK   = 2'd1,
        S_PRESSED     = 2'd2,
        S_RELEASE_CHK = 2'd3
    } btn_state_t;

    // Bit positions inside the {right,left,down,up} button vector
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    // Default timing at 100 MHz: 10 ms debounce, 500 ms repeat delay, 100 ms repeat period
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    // Largest of three counts; sizes the counters so every terminal value fits
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pong_btn_debounce.sv
// Single-button conditioner: two-flop synchroniser, four-state debounce FSM
// with a saturating stability counter, registered level/press/release.
// Optional macro PONG_AUTOREPEAT_EN adds a hold counter that emits extra
// press pulses while the button stays accepted as pressed.
module pong_btn_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_reg;
    logic             s2_reg;
    btn_state_t       state_reg;
    btn_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             level_reg;
    logic             level_next;
    logic             press_reg;
    logic             press_fsm;
    logic             press_next;
    logic             rel_reg;
    logic             rel_next;
    logic             rep_pulse;

    // Two-flop synchroniser; only s2_reg is seen by the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= raw;
            s2_reg <= s1_reg;
        end
    end

    // FSM state, stability counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_RELEASED;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            rel_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            press_reg <= press_next;
            rel_reg   <= rel_next;
        end
    end

    // Next-state logic; the counter is cleared on every transition so it never passes DB_LAST
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        press_fsm  = 1'b0;
        rel_next   = 1'b0;
        case (state_reg)
            S_RELEASED: begin
                if (s2_reg) begin
                    state_next = S_PRESS_CHK;
                    cnt_next   = '0;
                end
            end
            S_PRESS_CHK: begin
                if (!s2_reg) begin
                    state_next = S_RELEASED;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next = S_PRESSED;
                    cnt_next   = '0;
                    press_fsm  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (!s2_reg) begin
                    state_next = S_RELEASE_CHK;
                    cnt_next   = '0;
                end
            end
            S_RELEASE_CHK: begin
                if (s2_reg) begin
                    state_next = S_PRESSED;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next = S_RELEASED;
                    cnt_next   = '0;
                    rel_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_RELEASED;
                cnt_next   = '0;
            end
        endcase
        level_next = (state_next == S_PRESSED) || (state_next == S_RELEASE_CHK);
        press_next = press_fsm | rep_pulse;
    end

`ifdef PONG_AUTOREPEAT_EN
    logic [CNT_W-1:0] hold_reg;
    logic [CNT_W-1:0] hold_next;
    logic             first_done_reg;
    logic             first_done_next;

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // Hold counter register; cleared by reset and whenever the button leaves S_PRESSED
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg       <= '0;
            first_done_reg <= 1'b0;
        end else begin
            hold_reg       <= hold_next;
            first_done_reg <= first_done_next;
        end
    end

    // Repeat timing: first pulse REPEAT_DELAY after entering S_PRESSED, then every REPEAT_PERIOD
    always_comb begin
        hold_next       = '0;
        first_done_next = 1'b0;
        rep_pulse       = 1'b0;
        if (state_reg == S_PRESSED && s2_reg) begin
            first_done_next = first_done_reg;
            if (!first_done_reg && hold_reg == DELAY_LAST) begin
                rep_pulse       = 1'b1;
                first_done_next = 1'b1;
            end else if (first_done_reg && hold_reg == PERIOD_LAST) begin
                rep_pulse = 1'b1;
            end else begin
                hold_next = hold_reg + CNT_W'(1);
            end
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    assign level = level_reg;
    assign press = press_reg;
    assign rel   = rel_reg;

endmodule

// File: rtl/pong_btn_conditioner.sv
// Pong button front end: one debounce instance per button plus a registered
// one-hot direction code (priority up > down > left > right) for the paddle FSM.
// Optional macro PONG_AUTOREPEAT_EN enables auto-repeat press pulses.
// N_BTN must be at least 4 so that all four direction bits exist.
module pong_btn_conditioner
    import pong_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [3:0]       dir_onehot
);

    logic [3:0] dir_reg;
    logic [3:0] dir_next;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            pong_btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_debounce (
                .clk   (clk),
                .rst   (rst),
                .raw   (btn_raw[gi]),
                .level (btn_level[gi]),
                .press (btn_press[gi]),
                .rel   (btn_release[gi])
            );
        end
    endgenerate

    // Priority encode the debounced levels into a single direction bit
    always_comb begin
        dir_next = 4'b0000;
        if (btn_level[BTN_UP]) begin
            dir_next[BTN_UP] = 1'b1;
        end else if (btn_level[BTN_DOWN]) begin
            dir_next[BTN_DOWN] = 1'b1;
        end else if (btn_level[BTN_LEFT]) begin
            dir_next[BTN_LEFT] = 1'b1;
        end else if (btn_level[BTN_RIGHT]) begin
            dir_next[BTN_RIGHT] = 1'b1;
        end
    end

    // Direction register, one cycle behind btn_level
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_reg <= 4'b0000;
        end else begin
            dir_reg <= dir_next;
        end
    end

    assign dir_onehot = dir_reg;

endmodule

// File: tb/tb_pong_btn_conditioner.sv
// Self-checking bench for pong_btn_conditioner with short timing
// (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3). A behavioural model
// tracks, per button, how many consecutive synchronised samples disagree with
// the accepted level; the level flips once that run reaches DEBOUNCE_CYCLES+1.
module tb_pong_btn_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef PONG_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] dir_onehot;

    int n_checks = 0;
    int n_fail   = 0;

    pong_btn_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .dir_onehot  (dir_onehot)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [3:0] m_level = '0, m_press = '0, m_rel = '0, m_dir = '0;
    logic [3:0] m_hist0 = '0, m_hist1 = '0;   // raw delayed by one and two edges
    int         m_run [4];
    int         m_age [4];

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
    end

    always @(posedge clk) begin
        logic [3:0] lvl_n, prs_n, rel_n, dir_n;
        int run_n, age_n;
        if (rst) begin
            m_level <= '0; m_press <= '0; m_rel <= '0; m_dir <= '0;
            m_hist0 <= '0; m_hist1 <= '0;
            for (int i = 0; i < 4; i++) begin
                m_run[i] <= 0;
                m_age[i] <= 0;
            end
        end else begin
            lvl_n = m_level; prs_n = '0; rel_n = '0;
            for (int i = 0; i < 4; i++) begin
                run_n = m_run[i];
                age_n = m_age[i];
                if (m_hist1[i] != m_level[i]) begin
                    run_n = run_n + 1;
                    if (run_n == DB + 1) begin
                        lvl_n[i] = m_hist1[i];
                        run_n = 0;
                        age_n = 0;
                        if (m_hist1[i]) prs_n[i] = 1'b1;
                        else            rel_n[i] = 1'b1;
                    end
                end else if (run_n != 0) begin
                    run_n = 0;
                    age_n = 0;
                end else if (m_level[i]) begin
                    age_n = age_n + 1;
                    if (AUTO && (age_n == RD || (age_n > RD && (age_n - RD) % RP == 0)))
                        prs_n[i] = 1'b1;
                end
                m_run[i] <= run_n;
                m_age[i] <= age_n;
            end
            dir_n = 4'b0000;
            for (int i = 3; i >= 0; i--)
                if (m_level[i]) dir_n = 4'b0001 << i;
            m_level <= lvl_n;
            m_press <= prs_n;
            m_rel   <= rel_n;
            m_dir   <= dir_n;
            m_hist1 <= m_hist0;
            m_hist0 <= btn_raw;
        end
    end

    function automatic logic [15:0] obs();
        return {btn_level, btn_press, btn_release, dir_onehot};
    endfunction

    function automatic logic [15:0] expv();
        return {m_level, m_press, m_rel, m_dir};
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; btn_raw = 4'b0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs() !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", obs(), 16'h0000);
        end
        rst = 1'b0;
        $display("test_reset: outputs=%h", obs());
    endtask

    task automatic test_clean_press();
        btn_raw = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL clean_press_model k=%0d got=%h exp=%h", k, obs(), expv());
            end
            if (k == 6) begin
                n_checks++;
                if (btn_level[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clean_press_early k=6 level=%b exp=0", btn_level[0]);
                end
            end
            if (k == 7) begin
                n_checks++;
                if ({btn_level[0], btn_press[0]} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL clean_press_edge7 got=%b exp=11", {btn_level[0], btn_press[0]});
                end
            end
            if (k == 8) begin
                n_checks++;
                if ({btn_press[0], dir_onehot} !== 5'b0_0001) begin
                    n_fail++;
                    $display("FAIL clean_press_dir got=%b exp=00001", {btn_press[0], dir_onehot});
                end
            end
        end
        $display("test_clean_press: level=%b dir=%b", btn_level, dir_onehot);
    endtask

    task automatic test_bounce();
        int seq_v [7] = '{1, 0, 1, 0, 1, 0, 1};
        int seq_n [7] = '{1, 2, 2, 2, 3, 2, 14};
        int presses = 0;
        btn_raw = 4'b0000;
        settle(10);
        for (int s = 0; s < 7; s++) begin
            btn_raw[1] = seq_v[s][0];
            for (int k = 0; k < seq_n[s]; k++) begin
                @(negedge clk);
                n_checks++;
                if (obs() !== expv()) begin
                    n_fail++;
                    $display("FAIL bounce_model seg=%0d got=%h exp=%h", s, obs(), expv());
                end
                if (btn_press[1]) presses++;
            end
        end
        n_checks++;
        if (presses != 1 || btn_level[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_count presses=%0d level=%b exp presses=1 level=1", presses, btn_level[1]);
        end
        $display("test_bounce: presses=%0d level=%b", presses, btn_level);
    endtask

    task automatic test_release();
        // drop the held down button and check the release edge
        btn_raw[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL release_model k=%0d got=%h exp=%h", k, obs(), expv());
            end
            if (k == 7) begin
                n_checks++;
                if ({btn_level[1], btn_release[1]} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL release_edge7 got=%b exp=01", {btn_level[1], btn_release[1]});
                end
            end
        end
        // re-press, then a 2-cycle drop that must be swallowed
        btn_raw[1] = 1'b1;
        settle(10);
        btn_raw[1] = 1'b0;
        settle(2);
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== expv() || btn_level[1] !== 1'b1 || btn_press[1] || btn_release[1]) begin
                n_fail++;
                $display("FAIL release_bounce k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        btn_raw = 4'b0000;
        settle(10);
        $display("test_release: level=%b", btn_level);
    endtask

    task automatic test_priority();
        logic [3:0] pat [3] = '{4'b1010, 4'b1011, 4'b1010};
        logic [3:0] want [3] = '{4'b0010, 4'b0001, 4'b0010};
        for (int p = 0; p < 3; p++) begin
            btn_raw = pat[p];
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                n_checks++;
                if (obs() !== expv()) begin
                    n_fail++;
                    $display("FAIL priority_model p=%0d k=%0d got=%h exp=%h", p, k, obs(), expv());
                end
            end
            n_checks++;
            if (dir_onehot !== want[p]) begin
                n_fail++;
                $display("FAIL priority_dir p=%0d got=%b exp=%b", p, dir_onehot, want[p]);
            end
            $display("test_priority: raw=%b dir=%b", btn_raw, dir_onehot);
        end
        btn_raw = 4'b0000;
        settle(10);
    endtask

    task automatic test_reset_mid();
        btn_raw = 4'b0100;
        for (int phase = 0; phase < 2; phase++) begin
            settle(phase == 0 ? 4 : 10);   // phase 0: in S_PRESS_CHK, phase 1: in S_PRESSED
            rst = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs() !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_mid phase=%0d got=%h exp=0000", phase, obs());
            end
            rst = 1'b0;
            for (int k = 1; k <= 7; k++) begin
                @(negedge clk);
                n_checks++;
                if (obs() !== expv() || btn_level[2] !== (k == 7)) begin
                    n_fail++;
                    $display("FAIL reset_mid_relock phase=%0d k=%0d got=%h exp=%h", phase, k, obs(), expv());
                end
            end
            $display("test_reset_mid: phase=%0d level=%b", phase, btn_level);
        end
        btn_raw = 4'b0000;
        settle(10);
    endtask

    task automatic test_autorepeat();
        int presses = 0;
        int first_k = -1;
        int second_k = -1;
        btn_raw = 4'b1000;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL autorepeat_model k=%0d got=%h exp=%h", k, obs(), expv());
            end
            if (btn_press[3]) begin
                presses++;
                if (first_k < 0) first_k = k;
                else if (second_k < 0) second_k = k;
            end
        end
        n_checks++;
        if (AUTO) begin
            if (presses != 9 || first_k != 7 || second_k != 17) begin
                n_fail++;
                $display("FAIL autorepeat_count presses=%0d first=%0d second=%0d exp 9/7/17", presses, first_k, second_k);
            end
        end else begin
            if (presses != 1 || first_k != 7) begin
                n_fail++;
                $display("FAIL autorepeat_count presses=%0d first=%0d exp 1/7", presses, first_k);
            end
        end
        btn_raw = 4'b0000;
        settle(10);
        $display("test_autorepeat: presses=%0d first=%0d second=%0d", presses, first_k, second_k);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 4) == 0)
                btn_raw[$urandom_range(0, 3)] ^= 1'b1;
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            n_checks++;
            if (obs() !== expv() || $countones(dir_onehot) > 1) begin
                n_fail++;
                errs++;
                $display("FAIL random c=%0d got=%h exp=%h", c, obs(), expv());
            end
        end
        rst = 1'b0;
        $display("test_random: cycles=500 errors=%0d", errs);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_priority();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
